// File: rtl/bloom_pkg.sv
// Shared types, constants and the index hash for the Bloom-filter core.
// The hash maps one key to one IDX_W-bit index for hash number k:
// rotate left by (ROT_STEP*k) mod key_w, zero-pad to whole IDX_W chunks,
// XOR-fold the chunks, then XOR in (k*SEED_MULT) mod 2^idx_w.
// Widths are limited to HASH_MAX_KEY_W / HASH_MAX_IDX_W.
package bloom_pkg;

   localparam int ROT_STEP       = 7;
   localparam int SEED_MULT      = 'h2B5;
   localparam int HASH_MAX_KEY_W = 256;
   localparam int HASH_MAX_IDX_W = 24;

   typedef enum logic [1:0] {
      OP_QUERY  = 2'b00,
      OP_INSERT = 2'b01,
      OP_CLEAR  = 2'b10
   } op_e;

   typedef enum logic [2:0] {
      INIT_CLR,
      IDLE,
      HASH,
      PROBE,
      DRAIN,
      CLEAR,
      RESP
   } state_e;

   // Each key bit lands on output bit ((b + rot) mod key_w) mod idx_w,
   // which is the rotate-then-fold expressed one bit at a time.
   function automatic logic [HASH_MAX_IDX_W-1:0] bloom_hash(
      input logic [HASH_MAX_KEY_W-1:0] key,
      input int                        key_w,
      input int                        idx_w,
      input int                        k
   );
      logic [HASH_MAX_IDX_W-1:0] h;
      int rot;
      int pos;
      h   = '0;
      rot = (ROT_STEP * k) % key_w;
      for (int b = 0; b < HASH_MAX_KEY_W; b++) begin
         if (b < key_w) begin
            pos = ((b + rot) % key_w) % idx_w;
            h[pos[4:0]] = h[pos[4:0]] ^ key[b[7:0]];
         end
      end
      h = h ^ HASH_MAX_IDX_W'((k * SEED_MULT) % (1 << idx_w));
      return h;
   endfunction

endpackage

// File: rtl/bloom_filter_bram_core_hash.sv
// Combinational hash unit: produces all NUM_HASH indices for one key.
module bloom_hash_unit
   import bloom_pkg::*;
#(
   parameter int KEY_W    = 72,
   parameter int IDX_W    = 11,
   parameter int NUM_HASH = 7
) (
   input  logic [KEY_W-1:0]                 key,
   output logic [NUM_HASH-1:0][IDX_W-1:0]   idx
);

   logic [HASH_MAX_KEY_W-1:0] key_ext;
   assign key_ext = HASH_MAX_KEY_W'(key);

   for (genvar k = 0; k < NUM_HASH; k++) begin : g_hash
      logic [HASH_MAX_IDX_W-1:0] full;
      assign full   = bloom_hash(key_ext, KEY_W, IDX_W, k);
      assign idx[k] = full[IDX_W-1:0];
      if (IDX_W < HASH_MAX_IDX_W) begin : g_hi
         // Upper bits are always zero for this IDX_W.
         logic unused_hi;
         assign unused_hi = ^full[HASH_MAX_IDX_W-1:IDX_W];
      end
   end

endmodule

// File: rtl/bloom_filter_bram_core.sv
// Bloom-filter engine: insert / query / clear on a 2^IDX_W x 1 bit RAM.
// Handshake: a request is accepted in a cycle where req_valid && req_ready;
// req_ready is high only in IDLE. rsp_valid is a single-cycle pulse with no
// backpressure. Optional build macro BLOOM_EARLY_EXIT_EN: a query ends as soon
// as a probed bit reads back 0.
module bloom_filter_bram_core
   import bloom_pkg::*;
#(
   parameter int KEY_W    = 72,
   parameter int IDX_W    = 11,
   parameter int NUM_HASH = 7,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [KEY_W-1:0] req_key,
   output logic             rsp_valid,
   output logic             rsp_hit,
   output logic [CNT_W-1:0] item_cnt,
   output logic             busy
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int PK_W  = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;

   state_e                         state;
   op_e                            op_r;
   logic [KEY_W-1:0]               key_r;
   logic [NUM_HASH-1:0][IDX_W-1:0] idx_c;
   logic [NUM_HASH-1:0][IDX_W-1:0] idx_r;
   logic [IDX_W-1:0]               sweep;
   logic [PK_W-1:0]                pk;
   logic                           acc;
   logic                           rd_live;
   logic                           early_miss;

   logic                           mem [DEPTH];
   logic                           ram_we;
   logic                           ram_wd;
   logic                           ram_rd;
   logic [IDX_W-1:0]               ram_addr;

   bloom_hash_unit #(
      .KEY_W    (KEY_W),
      .IDX_W    (IDX_W),
      .NUM_HASH (NUM_HASH)
   ) u_hash (
      .key (key_r),
      .idx (idx_c)
   );

   // rd_live marks a cycle in which ram_rd holds a query probe result.
`ifdef BLOOM_EARLY_EXIT_EN
   assign early_miss = rd_live & ~ram_rd;
`else
   assign early_miss = 1'b0;
`endif

   // RAM port steering: sweeps write zeros, probes write ones (insert) or read.
   always_comb begin
      ram_we   = 1'b0;
      ram_wd   = 1'b0;
      ram_addr = '0;
      case (state)
         INIT_CLR, CLEAR: begin
            ram_we   = 1'b1;
            ram_addr = sweep;
         end
         PROBE: begin
            ram_we   = (op_r == OP_INSERT);
            ram_wd   = 1'b1;
            ram_addr = idx_r[pk];
         end
         default: ;
      endcase
   end

   // Single-port bit array, one-cycle read latency, no reset.
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wd;
      ram_rd <= mem[ram_addr];
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT_CLR;
         op_r      <= OP_QUERY;
         key_r     <= '0;
         idx_r     <= '0;
         sweep     <= '0;
         pk        <= '0;
         acc       <= 1'b0;
         rd_live   <= 1'b0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         item_cnt  <= '0;
         busy      <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rd_live   <= (state == PROBE) && (op_r == OP_QUERY);
         if (rd_live) acc <= acc & ram_rd;
         case (state)
            INIT_CLR: begin
               sweep <= sweep + IDX_W'(1);
               if (sweep == '1) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            IDLE: begin
               if (req_valid) begin
                  case (req_op)
                     2'b01:   op_r <= OP_INSERT;
                     2'b10:   op_r <= OP_CLEAR;
                     default: op_r <= OP_QUERY;
                  endcase
                  key_r     <= req_key;
                  sweep     <= '0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= (req_op == 2'b10) ? CLEAR : HASH;
               end
            end
            HASH: begin
               idx_r <= idx_c;
               pk    <= '0;
               acc   <= 1'b1;
               state <= PROBE;
            end
            PROBE: begin
               pk <= pk + PK_W'(1);
               if (early_miss) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else if (pk == PK_W'(NUM_HASH - 1)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_hit   <= (op_r == OP_QUERY) & acc & ram_rd;
               if (op_r == OP_INSERT && item_cnt != '1)
                  item_cnt <= item_cnt + CNT_W'(1);
            end
            CLEAR: begin
               sweep <= sweep + IDX_W'(1);
               if (sweep == '1) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  item_cnt  <= '0;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= INIT_CLR;
         endcase
      end
   end

endmodule

// File: tb/tb_bloom_filter_bram_core.sv
// Bench for bloom_filter_bram_core: random keys against a set-of-bits model.
module tb_bloom_filter_bram_core;

   localparam int KEY_W    = 72;
   localparam int IDX_W    = 11;
   localparam int NUM_HASH = 7;
   localparam int CNT_W    = 16;
   localparam int DEPTH    = 1 << IDX_W;
   localparam int NCH      = (KEY_W + IDX_W - 1) / IDX_W;
   localparam int BUDGET   = 5000;

   logic             clk;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [KEY_W-1:0] req_key;
   logic             rsp_valid;
   logic             rsp_hit;
   logic [CNT_W-1:0] item_cnt;
   logic             busy;

   bloom_filter_bram_core #(
      .KEY_W    (KEY_W),
      .IDX_W    (IDX_W),
      .NUM_HASH (NUM_HASH),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_key   (req_key),
      .rsp_valid (rsp_valid),
      .rsp_hit   (rsp_hit),
      .item_cnt  (item_cnt),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_cmp = 0;
   int          n_mis = 0;
   bit          model_bits [DEPTH];
   int          model_cnt;
   logic [31:0] exp_q [$];
   logic [KEY_W-1:0] stored [200];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference hash written as whole-vector rotate and chunk fold.
   function automatic logic [IDX_W-1:0] model_hash(input logic [KEY_W-1:0] key, input int k);
      logic [KEY_W-1:0]       rk;
      logic [NCH*IDX_W-1:0]   pad;
      logic [IDX_W-1:0]       h;
      int r;
      r  = (7 * k) % KEY_W;
      rk = (r == 0) ? key : ((key << r) | (key >> (KEY_W - r)));
      pad = '0;
      pad[KEY_W-1:0] = rk;
      h = '0;
      for (int c = 0; c < NCH; c++) h = h ^ pad[c*IDX_W +: IDX_W];
      h = h ^ IDX_W'((k * 'h2B5) % DEPTH);
      return h;
   endfunction

   function automatic logic [KEY_W-1:0] rand_key();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[KEY_W-1:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model_bits[i] = 1'b0;
      model_cnt = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_init(input string tag);
      int n;
      int bad_busy;
      int seen_rsp;
      n = 0; bad_busy = 0; seen_rsp = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (rsp_valid) seen_rsp++;
         if (!req_ready && busy !== 1'b1) bad_busy++;
      end while (!req_ready && n < 4000);
      check_eq({tag, "_cycles"},  32'(n), 32'(DEPTH));
      check_eq({tag, "_busy"},    32'(bad_busy), 32'd0);
      check_eq({tag, "_no_rsp"},  32'(seen_rsp), 32'd0);
      check_eq({tag, "_idle"},    32'(busy), 32'd0);
      check_eq({tag, "_cnt"},     32'(item_cnt), 32'd0);
   endtask

   task automatic do_op(input logic [1:0] op, input logic [KEY_W-1:0] key,
                        input string tag, output logic hit);
      logic        exp_hit;
      int          exp_lat;
      int          first0;
      int          w;
      int          lat;
      logic        got;
      logic [31:0] e_hit;
      logic [31:0] e_lat;
      exp_hit = 1'b0;
      if (op == 2'b10) begin
         exp_lat = DEPTH + 1;
      end else if (op == 2'b01) begin
         exp_lat = NUM_HASH + 3;
      end else begin
         first0 = -1;
         for (int k = 0; k < NUM_HASH; k++)
            if (!model_bits[model_hash(key, k)] && first0 < 0) first0 = k;
         exp_hit = (first0 < 0);
         exp_lat = NUM_HASH + 3;
`ifdef BLOOM_EARLY_EXIT_EN
         if (first0 >= 0) exp_lat = first0 + 4;
`endif
      end
      exp_q.push_back(32'(exp_hit));
      exp_q.push_back(32'(exp_lat));

      w = 0;
      @(negedge clk);
      while (!req_ready && w < BUDGET) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_key   = key;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      got = 1'b0;
      hit = 1'b0;
      while (lat <= BUDGET) begin
         if (rsp_valid) begin
            got = 1'b1;
            hit = rsp_hit;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
      e_hit = exp_q.pop_front();
      e_lat = exp_q.pop_front();
      check_eq({tag, "_lat"}, 32'(lat), e_lat);
      check_eq({tag, "_hit"}, 32'(hit), e_hit);

      if (op == 2'b01) begin
         for (int k = 0; k < NUM_HASH; k++) model_bits[model_hash(key, k)] = 1'b1;
         if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
      end else if (op == 2'b10) begin
         model_reset();
      end

      if (got) begin
         @(posedge clk); #1;
         check_eq({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
         check_eq({tag, "_cnt"},   32'(item_cnt), 32'(model_cnt));
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic h;
      int   got_miss;
      int   exp_miss;
      int   hits;
      logic [KEY_W-1:0] k;
      logic [1:0] cur_op;

      rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_key = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_rsp",   32'(rsp_valid), 32'd0);
      check_eq("rst_hit",   32'(rsp_hit),   32'd0);
      check_eq("rst_cnt",   32'(item_cnt),  32'd0);
      check_eq("rst_busy",  32'(busy),      32'd1);
      @(negedge clk);
      rst = 1'b0;
      wait_init("init");

      do_op(2'b00, '0, "q_zero_empty", h);
      do_op(2'b01, KEY_W'(64'h0123456789ABCDEF), "ins_fixed", h);
      do_op(2'b00, KEY_W'(64'h0123456789ABCDEF), "q_fixed", h);
      do_op(2'b00, KEY_W'(64'hFFFFFFFFFFFFFFFF), "q_ones", h);
      do_op(2'b11, KEY_W'(64'h0123456789ABCDEF), "q_rsvd_op", h);

      for (int i = 0; i < 200; i++) begin
         stored[i] = rand_key();
         do_op(2'b01, stored[i], "ins_rand", h);
      end
      hits = 0;
      for (int i = 0; i < 200; i++) begin
         cur_op = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
         do_op(cur_op, stored[i], "q_stored", h);
         if (h) hits++;
      end
      check_eq("stored_all_hit", 32'(hits), 32'd200);

      got_miss = 0; exp_miss = 0;
      for (int i = 0; i < 1000; i++) begin
         k = rand_key();
         for (int j = 0; j < NUM_HASH; j++)
            if (!model_bits[model_hash(k, j)]) begin
               exp_miss++;
               break;
            end
         do_op(2'b00, k, "q_fresh", h);
         if (!h) got_miss++;
      end
      check_eq("fresh_miss_count", 32'(got_miss), 32'(exp_miss));

      do_op(2'b10, '0, "clear", h);
      for (int i = 0; i < 20; i++) do_op(2'b00, stored[i], "q_after_clear", h);

      // Abort an insert with reset partway through the probes.
      for (int i = 0; i < 5; i++) do_op(2'b01, stored[i], "ins_pre_rst", h);
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_key = stored[7];
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("midrst_rsp",   32'(rsp_valid), 32'd0);
      check_eq("midrst_busy",  32'(busy),      32'd1);
      check_eq("midrst_ready", 32'(req_ready), 32'd0);
      check_eq("midrst_cnt",   32'(item_cnt),  32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      wait_init("reinit");
      for (int i = 0; i < 8; i++) do_op(2'b00, stored[i], "q_after_rst", h);
      do_op(2'b01, stored[0], "ins_post_rst", h);
      do_op(2'b00, stored[0], "q_post_rst", h);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
